// File: rtl/prog_instruction_memory_pkg.sv
// prog_instruction_memory_pkg: shared FSM encoding and default NOP word for the instruction memory.
package prog_instruction_memory_pkg;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_CLEAR} state_t;
    localparam logic [15:0] NOP_DEFAULT = 16'hF800;
endpackage

// File: rtl/prog_instruction_memory_imem_array.sv
// imem_array: one write port, one asynchronous read port storage, NOP-filled at power-up.
module imem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH = 256,
    parameter int IW = 8,
    parameter logic [DATA_W-1:0] INIT = '0
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [IW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH] = '{default: INIT};
    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/prog_instruction_memory.sv
// prog_instruction_memory: program memory with latency-padded fetch handshake, load port and NOP-fill clear.
module prog_instruction_memory
    import prog_instruction_memory_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH = 256,
    parameter int WAIT_CYCLES = 1,
    parameter logic [DATA_W-1:0] NOP_WORD = NOP_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] pc,
    output logic              ready,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instruction,
    output logic              fault,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              clear,
    output logic              busy
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [3:0] W_LAST = 4'(WAIT_CYCLES - 1);
    localparam logic [IW-1:0] S_LAST = IW'(DEPTH - 1);
    state_t r_state;
    logic [3:0] r_wait;
    logic [IW-1:0] r_sweep;
    logic [DATA_W-1:0] r_data;
    logic r_fault;
    logic w_idle, w_oob, w_load_ok, w_we, w_accept;
    logic [IW-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata, w_rdata;
    assign w_idle = r_state == S_IDLE;
    assign w_oob = 32'(pc) >= 32'(DEPTH);
    assign w_load_ok = 32'(load_addr) < 32'(DEPTH);
    assign ready = w_idle && !load_en && !clear;
    assign w_accept = ready && req;
    assign busy = r_state == S_CLEAR;
    assign instr_valid = r_state == S_RESP;
    assign instruction = instr_valid ? r_data : NOP_WORD;
    assign fault = instr_valid && r_fault;
    // The sweep owns the write port; a clear request in IDLE suppresses a simultaneous load.
    assign w_we = !rst && (busy || (load_en && w_load_ok && !(w_idle && clear)));
    assign w_waddr = busy ? r_sweep : load_addr[IW-1:0];
    assign w_wdata = busy ? NOP_WORD : load_data;
    imem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IW(IW), .INIT(NOP_WORD)) u_array (
        .clk(clk),
        .i_we(w_we),
        .i_waddr(w_waddr),
        .i_wdata(w_wdata),
        .i_raddr(pc[IW-1:0]),
        .o_rdata(w_rdata)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wait <= '0;
            r_sweep <= '0;
            r_data <= NOP_WORD;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clear) begin
                        r_state <= S_CLEAR;
                        r_sweep <= '0;
                    end else if (w_accept) begin
                        r_data <= w_oob ? '0 : w_rdata;
                        r_fault <= w_oob;
                        r_wait <= '0;
                        r_state <= WAIT_CYCLES > 0 ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    if (r_wait == W_LAST) r_state <= S_RESP;
                    else r_wait <= r_wait + 4'd1;
                end
                S_RESP: if (instr_ready) r_state <= S_IDLE;
                S_CLEAR: begin
                    if (r_sweep == S_LAST) r_state <= S_IDLE;
                    else r_sweep <= r_sweep + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_instruction_memory.sv
// tb_prog_instruction_memory: directed checks of fetch latency, loads, clear sweep and reset.
module tb_prog_instruction_memory;
    logic clk, rst, req, ready, instr_valid, instr_ready, fault, load_en, clear, busy;
    logic [15:0] pc, instruction, load_addr, load_data;
    int errors = 0;
    int checks = 0;
    int cnt;
    prog_instruction_memory dut (
        .clk(clk), .rst(rst), .req(req), .pc(pc), .ready(ready),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .fault(fault), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .clear(clear), .busy(busy)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic load(input logic [15:0] a, input logic [15:0] d);
        load_en = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en = 1'b0;
    endtask
    task automatic fetch(input string tag, input logic [15:0] a, input logic [15:0] exp_i,
                         input logic exp_f, input int hold);
        req = 1'b1;
        pc = a;
        #1;
        chk({tag, ".ready"}, 32'(ready), 32'd1);
        step();
        req = 1'b0;
        chk({tag, ".wait_valid"}, 32'(instr_valid), 32'd0);
        step();
        chk({tag, ".valid"}, 32'(instr_valid), 32'd1);
        chk({tag, ".instr"}, 32'(instruction), 32'(exp_i));
        chk({tag, ".fault"}, 32'(fault), 32'(exp_f));
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, ".hold_valid"}, 32'(instr_valid), 32'd1);
            chk({tag, ".hold_instr"}, 32'(instruction), 32'(exp_i));
            chk({tag, ".hold_ready"}, 32'(ready), 32'd0);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk({tag, ".done_valid"}, 32'(instr_valid), 32'd0);
    endtask
    initial begin
        rst = 1'b1; req = 1'b0; pc = '0; instr_ready = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0; clear = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst.valid", 32'(instr_valid), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.fault", 32'(fault), 32'd0);
        chk("rst.instr", 32'(instruction), 32'hF800);
        chk("rst.ready", 32'(ready), 32'd1);
        fetch("init5", 16'd5, 16'hF800, 1'b0, 0);
        load(16'd0, 16'h0468);
        fetch("pc0", 16'd0, 16'h0468, 1'b0, 0);
        fetch("pc300", 16'd300, 16'h0000, 1'b1, 0);
        fetch("hold", 16'd0, 16'h0468, 1'b0, 5);
        // load has priority over req
        load_en = 1'b1; load_addr = 16'd1; load_data = 16'hABCD; req = 1'b1; pc = 16'd0;
        #1;
        chk("prio.ready", 32'(ready), 32'd0);
        step();
        load_en = 1'b0; req = 1'b0;
        step();
        chk("prio.no_fetch", 32'(instr_valid), 32'd0);
        load(16'd257, 16'hDEAD);
        fetch("pc1", 16'd1, 16'hABCD, 1'b0, 0);
        load(16'd255, 16'h7FFF);
        fetch("pc255", 16'd255, 16'h7FFF, 1'b0, 0);
        fetch("pc256", 16'd256, 16'h0000, 1'b1, 0);
        // load during WAIT does not disturb the in-flight word
        load(16'd9, 16'h1111);
        req = 1'b1; pc = 16'd9;
        step();
        req = 1'b0;
        load_en = 1'b1; load_addr = 16'd9; load_data = 16'h1359;
        step();
        load_en = 1'b0;
        chk("ovl.valid", 32'(instr_valid), 32'd1);
        chk("ovl.instr", 32'(instruction), 32'h1111);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        fetch("pc9_new", 16'd9, 16'h1359, 1'b0, 0);
        // clear wins over a simultaneous load; req and load ignored while busy
        load(16'd3, 16'h3030);
        clear = 1'b1; load_en = 1'b1; load_addr = 16'd2; load_data = 16'h2222;
        step();
        clear = 1'b0;
        req = 1'b1; pc = 16'd0; load_addr = 16'd3; load_data = 16'h3333;
        cnt = 0;
        while (busy && cnt < 400) begin
            cnt++;
            step();
        end
        req = 1'b0; load_en = 1'b0;
        chk("clr.cycles", 32'(cnt), 32'd256);
        chk("clr.no_fetch", 32'(instr_valid), 32'd0);
        fetch("clr0", 16'd0, 16'hF800, 1'b0, 0);
        fetch("clr2", 16'd2, 16'hF800, 1'b0, 0);
        fetch("clr3", 16'd3, 16'hF800, 1'b0, 0);
        fetch("clr9", 16'd9, 16'hF800, 1'b0, 0);
        fetch("clr255", 16'd255, 16'hF800, 1'b0, 0);
        // reset in the middle of WAIT
        req = 1'b1; pc = 16'd0;
        step();
        req = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rstw.ready", 32'(ready), 32'd1);
        chk("rstw.valid", 32'(instr_valid), 32'd0);
        chk("rstw.busy", 32'(busy), 32'd0);
        // reset in the middle of a sweep keeps the partial result
        load(16'd5, 16'h5555);
        load(16'd200, 16'hAAAA);
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("rstc.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rstc.ready", 32'(ready), 32'd1);
        chk("rstc.valid", 32'(instr_valid), 32'd0);
        chk("rstc.busy", 32'(busy), 32'd0);
        fetch("rstc5", 16'd5, 16'hF800, 1'b0, 0);
        fetch("rstc200", 16'd200, 16'hAAAA, 1'b0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
